ser_frame_rx: RTL and testbench
===============================

Name: ser_frame_rx

Overview:
Serial frame receiver that sits directly downstream of the universal shift register's serial output. It consumes the bit stream shifted out in right-shift or left-shift mode, delineates start/data/parity/stop framing and reassembles a parallel word. It flags parity and framing errors and presents each completed word with a one-cycle valid pulse to the parallel consumer.

Parameters:
WIDTH, 4, data bits per frame (legal range 2..16).
PARITY_EN, 1, 1 = frame carries an even-parity bit after the data; 0 = no parity bit.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous active-low reset (negedge rst clears all state immediately).
sin  input  1  serial bit from the upstream shift register; idle level 1.
sin_en  input  1  bit strobe; sin is sampled only on posedges where sin_en=1.
dir  input  1  bit order: 0 = LSB first (right-shift source), 1 = MSB first (left-shift source).
data_out  output  WIDTH  last successfully received word.
data_valid  output  1  one-cycle pulse; data_out updated this cycle.
parity_err  output  1  parity check result, qualified by data_valid.
frame_err  output  1  one-cycle pulse; stop bit sampled as 0.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, async): FSM=IDLE; bit counter, shift reg, latched dir and parity bit = 0; data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0. Reset asserted mid-frame aborts the frame with no output pulse.
- sin_en=0: FSM, counter and shift reg hold. Only data_valid and frame_err drop to 0, since both are single-cycle pulses. Arbitrary gaps between bits are legal.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE:
  - sin_en & sin=0 (start bit): go to DATA. Clear the counter and shift reg. Latch dir.
  - sin_en & sin=1: stay in IDLE.
- DATA, on each sin_en:
  - Latched dir=0: shreg <= {sin, shreg[WIDTH-1:1]}, so the first bit ends up at bit 0.
  - Latched dir=1: shreg <= {shreg[WIDTH-2:0], sin}, so the first bit ends up at the MSB.
  - Counter increments.
  - On the strobe where counter==WIDTH-1: go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: on sin_en, latch the parity bit and go to STOP.
- STOP, on sin_en (always returns to IDLE on this strobe):
  - sin=1: data_out <= shreg; data_valid=1 for exactly the next cycle.
  - sin=1 and PARITY_EN=1: parity_err <= (^shreg) XOR parity_bit, i.e. even parity, total ones including the parity bit must be even.
  - sin=1 and PARITY_EN=0: parity_err <= 0.
  - sin=0: frame_err=1 for exactly the next cycle. data_valid stays 0. data_out and parity_err hold their previous values.
- parity_err is a level that holds until the next good frame updates it.
- Latency: data_valid is high during the cycle following the posedge that samples the stop bit.
- Back-to-back frames: a start bit may be sampled on the first sin_en after the stop strobe, with no idle bit required.
- Changes to dir mid-frame are ignored. Only the value latched at the start bit applies.
- busy=1 from the edge that samples the start bit until the edge that samples the stop bit.

Test Plan:
(WIDTH=4, PARITY_EN=1; one bit per sin_en strobe unless noted.)
1. Reset: hold rst=0 for 2 cycles with random sin/sin_en -> data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0. Then release rst with sin=1 and sin_en=1 -> FSM stays in IDLE, busy=0.
2. LSB-first good frame: dir=0, stream 0 | 1,0,1,1 | 1 | 1 -> one data_valid pulse, data_out=4'hD, parity_err=0, frame_err=0, busy low after the stop bit.
3. MSB-first: dir=1, same stream -> data_out=4'hB, parity_err=0. Toggling dir during the data bits has no effect.
4. Parity error: dir=0, stream 0 | 1,0,1,1 | 0 | 1 -> data_out=4'hD, data_valid pulse, parity_err=1. A following good frame with data 0,0,0,0 and parity 0 -> data_out=4'h0, parity_err=0.
5. Framing error: stream 0 | 0,1,1,0 | 0 | 0 -> frame_err single-cycle pulse, no data_valid, data_out retains its previous value, FSM back in IDLE.
6. Gaps, reset and back-to-back:
   - Insert 0-3 random cycles of sin_en=0 between the bits of scenario 2 -> identical result.
   - Assert rst after 2 data bits -> busy=0 and no pulse. The next full frame is decoded correctly.
   - Two frames with no idle bit between them (first data 4'hD, second data 4'h3, parity 0) -> two data_valid pulses with data_out=4'hD then 4'h3.

Source files
------------

// File: rtl/ser_frame_rx.sv
// Serial frame receiver: start / WIDTH data / optional even parity / stop.
// Reassembles the word in the bit order latched at the start bit.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (sin=0)
// DATA   | shifting in WIDTH data bits
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit, publishing word or framing error
module ser_frame_rx #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             dir,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dir_q, dir_d;
  logic             pbit_q, pbit_d;
  logic [WIDTH-1:0] dout_d;
  logic             dv_d, perr_d, ferr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dir_d   = dir_q;
    pbit_d  = pbit_q;
    dout_d  = data_out;
    dv_d    = 1'b0;
    perr_d  = parity_err;
    ferr_d  = 1'b0;
    if (sin_en) begin
      case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d = DATA;
            cnt_d   = '0;
            shreg_d = '0;
            dir_d   = dir;
          end
        end
        DATA: begin
          // dir_q=0: first bit drifts down to bit 0; dir_q=1: first bit ends at MSB
          shreg_d = dir_q ? {shreg_q[WIDTH-2:0], sin} : {sin, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          pbit_d  = sin;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (sin) begin
            dout_d = shreg_q;
            dv_d   = 1'b1;
            perr_d = PARITY_EN ? ((^shreg_q) ^ pbit_q) : 1'b0;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      shreg_q    <= '0;
      dir_q      <= 1'b0;
      pbit_q     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      dir_q      <= dir_d;
      pbit_q     <= pbit_d;
      data_out   <= dout_d;
      data_valid <= dv_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_ser_frame_rx.sv
// Self-checking bench for ser_frame_rx (WIDTH=4, even parity enabled).
// Expected words come from a bit-position model of the serial stream.
module tb_ser_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_en;
  logic       dir;
  logic [3:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_dout;
  logic       exp_perr;

  ser_frame_rx #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .dir(dir),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word value from bits in arrival order: bit i lands at position i (LSB first)
  // or at position 3-i (MSB first).
  function automatic logic [3:0] ref_word(input logic [3:0] s, input logic d);
    int v;
    v = 0;
    for (int i = 0; i < 4; i++)
      if (s[i]) v += d ? (1 << (3 - i)) : (1 << i);
    return v[3:0];
  endfunction

  task automatic strobe(input logic b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin
      sin    = 1'($urandom_range(1, 0));
      sin_en = 1'b0;
      @(negedge clk);
    end
    sin    = b;
    sin_en = 1'b1;
    @(negedge clk);
    sin_en = 1'b0;
    sin    = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [3:0] s, input logic d,
                           input logic pb, input logic stop, input int maxgap,
                           input bit toggle, input bit b2b);
    logic [3:0] w;
    w   = ref_word(s, d);
    dir = d;
    strobe(1'b0, maxgap);
    chk({tag, " busy_start"}, 16'(busy), 16'd1);
    for (int i = 0; i < 4; i++) begin
      if (toggle) dir = ~dir;
      strobe(s[i], maxgap);
    end
    strobe(pb, maxgap);
    strobe(stop, maxgap);
    if (stop) begin
      exp_dout = w;
      exp_perr = 1'((($countones(w) + int'(pb)) % 2));
    end
    chk({tag, " data_valid"}, 16'(data_valid), 16'(stop));
    chk({tag, " frame_err"},  16'(frame_err),  16'(!stop));
    chk({tag, " data_out"},   16'(data_out),   16'(exp_dout));
    chk({tag, " parity_err"}, 16'(parity_err), 16'(exp_perr));
    chk({tag, " busy_end"},   16'(busy),       16'd0);
    if (!b2b) begin
      @(negedge clk);
      chk({tag, " dv_pulse"}, 16'(data_valid), 16'd0);
      chk({tag, " fe_pulse"}, 16'(frame_err),  16'd0);
    end
  endtask

  initial begin
    rst    = 1'b0;
    sin    = 1'b1;
    sin_en = 1'b0;
    dir    = 1'b0;
    exp_dout = 4'h0;
    exp_perr = 1'b0;

    // Reset with random line activity
    repeat (2) begin
      sin    = 1'($urandom_range(1, 0));
      sin_en = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    chk("rst data_out",   16'(data_out),   16'd0);
    chk("rst data_valid", 16'(data_valid), 16'd0);
    chk("rst parity_err", 16'(parity_err), 16'd0);
    chk("rst frame_err",  16'(frame_err),  16'd0);
    chk("rst busy",       16'(busy),       16'd0);
    sin = 1'b1; sin_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle busy", 16'(busy), 16'd0);
    @(negedge clk);
    chk("idle busy2", 16'(busy), 16'd0);
    sin_en = 1'b0;

    run_frame("lsb",      4'b1101, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    chk("lsb word", 16'(data_out), 16'hD);
    run_frame("msb",      4'b1101, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    chk("msb word", 16'(data_out), 16'hB);
    run_frame("msb_tog",  4'b1101, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    chk("msb_tog word", 16'(data_out), 16'hB);
    run_frame("perr",     4'b1101, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("perr level", 16'(parity_err), 16'd1);
    run_frame("perr_clr", 4'b0000, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("perr_clr level", 16'(parity_err), 16'd0);
    run_frame("ferr",     4'b0110, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_frame("gaps",     4'b1101, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    chk("gaps word", 16'(data_out), 16'hD);

    // Reset after two data bits aborts the frame
    dir = 1'b0;
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    #2 rst = 1'b0;
    #1;
    exp_dout = 4'h0;
    exp_perr = 1'b0;
    chk("midrst busy",       16'(busy),       16'd0);
    chk("midrst data_valid", 16'(data_valid), 16'd0);
    chk("midrst data_out",   16'(data_out),   16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst idle dv", 16'(data_valid), 16'd0);
    run_frame("after_rst", 4'b1101, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);

    run_frame("b2b_a", 4'b1101, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    chk("b2b_a word", 16'(data_out), 16'hD);
    run_frame("b2b_b", 4'b0011, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("b2b_b word", 16'(data_out), 16'h3);

    for (int n = 0; n < 24; n++) begin
      run_frame($sformatf("rnd%0d", n),
                4'($urandom_range(15, 0)),
                1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)),
                1'($urandom_range(9, 0) != 0),
                int'($urandom_range(3, 0)),
                1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)));
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
